// File: rtl/spu_pkg.sv
// Shared widths, instruction/line types and issue-buffer state encoding.
package spu_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_W       = 8;
  localparam int LINE_WORDS = 16;

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [LINE_WORDS-1:0][INSTR_W-1:0] line_t;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/instr_issue_buffer.sv
// Fetches a 16-word line, then issues it as even/odd pairs: first pair one cycle after line_valid.
// stall freezes the current pair; flush overrides everything and refetches at the redirect target.
module instr_issue_buffer
  import spu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic            read_enable,
  output logic [PC_W-1:0] fetch_pc,
  input  line_t           line_in,
  input  logic            line_valid,
  output instr_t          instr_even,
  output instr_t          instr_odd,
  output logic [PC_W-1:0] pc_out,
  output logic            even_valid,
  output logic            odd_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc
);

  state_t     state;
  line_t      line_q;
  logic [3:0] idx;
  logic [3:0] idx_odd;
  logic       skip_even;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      fetch_pc  <= '0;
      idx       <= '0;
      skip_even <= 1'b0;
      line_q    <= '0;
    end else if (flush) begin
      // Redirect to the aligned line; an odd target hides the even slot of its first pair.
      state     <= FETCH;
      fetch_pc  <= {flush_pc[7:4], 4'b0000};
      idx       <= {flush_pc[3:1], 1'b0};
      skip_even <= flush_pc[0];
    end else begin
      case (state)
        FETCH: begin
          if (line_valid) begin
            line_q <= line_in;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            skip_even <= 1'b0;
            if (idx == 4'd14) begin
              state    <= FETCH;
              fetch_pc <= fetch_pc + 8'd16;
              idx      <= '0;
            end else begin
              idx <= idx + 4'd2;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign idx_odd     = {idx[3:1], 1'b1};
  assign read_enable = (state == FETCH);
  assign odd_valid   = (state == ISSUE);
  assign even_valid  = (state == ISSUE) && !skip_even;
  assign instr_even  = line_q[idx];
  assign instr_odd   = line_q[idx_odd];
  assign pc_out      = fetch_pc + {4'b0000, idx};

endmodule

// File: tb/tb_instr_issue_buffer.sv
// Directed bench for instr_issue_buffer: reset, streaming, stall, odd flush, wrap, priorities.
module tb_instr_issue_buffer;
  import spu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_enable;
  logic [7:0] fetch_pc;
  line_t      line_in;
  logic       line_valid;
  instr_t     instr_even;
  instr_t     instr_odd;
  logic [7:0] pc_out;
  logic       even_valid;
  logic       odd_valid;
  logic       stall;
  logic       flush;
  logic [7:0] flush_pc;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  instr_issue_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .read_enable(read_enable),
    .fetch_pc   (fetch_pc),
    .line_in    (line_in),
    .line_valid (line_valid),
    .instr_even (instr_even),
    .instr_odd  (instr_odd),
    .pc_out     (pc_out),
    .even_valid (even_valid),
    .odd_valid  (odd_valid),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc)
  );

  // Advance one clock; outputs are observed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int i = 0; i < 16; i++) line_in[i] = base + i;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; stall = 1'b0; line_valid = 1'b0;
    flush_pc = '0; line_in = '0;
    tick(); tick();
    checks++; if (read_enable !== 1'b1) $display("FAIL rst_read_enable got %0b want 1", read_enable); else passed++;
    checks++; if (fetch_pc !== 8'd0) $display("FAIL rst_fetch_pc got %0d want 0", fetch_pc); else passed++;
    checks++; if ({even_valid, odd_valid} !== 2'b00) $display("FAIL rst_valids got %b want 00", {even_valid, odd_valid}); else passed++;
    checks++; if ({instr_even, instr_odd} !== 64'd0) $display("FAIL rst_instr got %h want 0", {instr_even, instr_odd}); else passed++;
    checks++; if (pc_out !== 8'd0) $display("FAIL rst_pc_out got %0d want 0", pc_out); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    set_line(32'h1000);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (pc_out !== 8'(2*k)) $display("FAIL stream_pc_out got %0d want %0d", pc_out, 2*k); else passed++;
      checks++; if (instr_even !== 32'h1000 + 2*k) $display("FAIL stream_even got %h want %h", instr_even, 32'h1000 + 2*k); else passed++;
      checks++; if (instr_odd !== 32'h1001 + 2*k) $display("FAIL stream_odd got %h want %h", instr_odd, 32'h1001 + 2*k); else passed++;
      checks++; if ({read_enable, even_valid, odd_valid} !== 3'b011) $display("FAIL stream_flags got %b want 011", {read_enable, even_valid, odd_valid}); else passed++;
      tick();
    end
    checks++; if (read_enable !== 1'b1 || fetch_pc !== 8'd16) $display("FAIL stream_next_fetch got re=%0b pc=%0d want re=1 pc=16", read_enable, fetch_pc); else passed++;
    checks++; if ({even_valid, odd_valid} !== 2'b00) $display("FAIL stream_fetch_valids got %b want 00", {even_valid, odd_valid}); else passed++;
  endtask

  task automatic test_stall();
    flush = 1'b1; flush_pc = 8'd0;
    tick();
    flush = 1'b0;
    set_line(32'h1000);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (pc_out !== 8'd6) $display("FAIL stall_setup_pc got %0d want 6", pc_out); else passed++;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc_out !== 8'd6 || instr_even !== 32'h1006 || instr_odd !== 32'h1007)
        $display("FAIL stall_hold got pc=%0d even=%h odd=%h want pc=6 even=1006 odd=1007", pc_out, instr_even, instr_odd); else passed++;
    end
    stall = 1'b0;
    tick();
    checks++; if (pc_out !== 8'd8 || instr_even !== 32'h1008) $display("FAIL stall_release got pc=%0d even=%h want pc=8 even=1008", pc_out, instr_even); else passed++;
  endtask

  task automatic test_flush_odd();
    flush = 1'b1; flush_pc = 8'd37;
    tick();
    flush = 1'b0;
    checks++; if (read_enable !== 1'b1 || fetch_pc !== 8'd32) $display("FAIL flush_fetch got re=%0b pc=%0d want re=1 pc=32", read_enable, fetch_pc); else passed++;
    set_line(32'h3000);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    checks++; if (pc_out !== 8'd36) $display("FAIL odd_first_pc got %0d want 36", pc_out); else passed++;
    checks++; if ({even_valid, odd_valid} !== 2'b01) $display("FAIL odd_first_valids got %b want 01", {even_valid, odd_valid}); else passed++;
    checks++; if (instr_odd !== 32'h3005) $display("FAIL odd_first_instr got %h want 3005", instr_odd); else passed++;
    tick();
    checks++; if (pc_out !== 8'd38 || {even_valid, odd_valid} !== 2'b11 || instr_even !== 32'h3006)
      $display("FAIL odd_second got pc=%0d v=%b even=%h want pc=38 v=11 even=3006", pc_out, {even_valid, odd_valid}, instr_even); else passed++;
  endtask

  task automatic test_wrap();
    flush = 1'b1; flush_pc = 8'd240;
    tick();
    flush = 1'b0;
    set_line(32'h5000);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    checks++; if (pc_out !== 8'd240 || instr_even !== 32'h5000) $display("FAIL wrap_first got pc=%0d even=%h want pc=240 even=5000", pc_out, instr_even); else passed++;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (read_enable !== 1'b1 || fetch_pc !== 8'd0) $display("FAIL wrap_fetch got re=%0b pc=%0d want re=1 pc=0", read_enable, fetch_pc); else passed++;
  endtask

  task automatic test_priority();
    set_line(32'h9000);
    flush = 1'b1; flush_pc = 8'h52; line_valid = 1'b1;
    tick();
    flush = 1'b0; line_valid = 1'b0;
    checks++; if (read_enable !== 1'b1 || fetch_pc !== 8'h50 || odd_valid !== 1'b0)
      $display("FAIL flush_vs_line got re=%0b pc=%h ov=%0b want re=1 pc=50 ov=0", read_enable, fetch_pc, odd_valid); else passed++;
    set_line(32'h4000);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    checks++; if (pc_out !== 8'h52 || instr_even !== 32'h4002 || {even_valid, odd_valid} !== 2'b11)
      $display("FAIL prio_issue got pc=%h even=%h v=%b want pc=52 even=4002 v=11", pc_out, instr_even, {even_valid, odd_valid}); else passed++;
    set_line(32'hBEEF0000);
    stall = 1'b1; line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    checks++; if (instr_even !== 32'h4002 || pc_out !== 8'h52) $display("FAIL line_in_issue got pc=%h even=%h want pc=52 even=4002", pc_out, instr_even); else passed++;
    flush = 1'b1; flush_pc = 8'h80;
    tick();
    flush = 1'b0; stall = 1'b0;
    checks++; if (read_enable !== 1'b1 || fetch_pc !== 8'h80 || odd_valid !== 1'b0)
      $display("FAIL flush_vs_stall got re=%0b pc=%h ov=%0b want re=1 pc=80 ov=0", read_enable, fetch_pc, odd_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    flush = 1'b1; flush_pc = 8'd10;
    tick();
    flush = 1'b0;
    set_line(32'h7000);
    line_valid = 1'b1;
    tick();
    line_valid = 1'b0;
    checks++; if (pc_out !== 8'd10 || instr_even !== 32'h700A) $display("FAIL mid_setup got pc=%0d even=%h want pc=10 even=700a", pc_out, instr_even); else passed++;
    reset = 1'b1; flush = 1'b1; flush_pc = 8'h44;
    tick();
    reset = 1'b0; flush = 1'b0;
    checks++; if (read_enable !== 1'b1 || fetch_pc !== 8'd0 || {even_valid, odd_valid} !== 2'b00)
      $display("FAIL mid_reset got re=%0b pc=%0d v=%b want re=1 pc=0 v=00", read_enable, fetch_pc, {even_valid, odd_valid}); else passed++;
    checks++; if (instr_even !== 32'd0 || pc_out !== 8'd0) $display("FAIL mid_reset_line got even=%h pc=%0d want 0 0", instr_even, pc_out); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_odd();
    test_wrap();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_issue_buffer.md
INSTR_ISSUE_BUFFER -- requirements
Module: instr_issue_buffer

Interface
REQ-001 The module SHALL have exactly one clock domain; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 read_enable  output  1  line fetch request to the instruction-line source; high in FETCH only.
REQ-005 fetch_pc  output  8  word address of the requested line; low 4 bits always 0.
REQ-006 line_in  input  16x32  fetched line, word 0 = instruction at fetch_pc.
REQ-007 line_valid  input  1  line_in holds the line for the current fetch_pc.
REQ-008 instr_even  output  32  instruction at pc_out (even slot).
REQ-009 instr_odd  output  32  instruction at pc_out+1 (odd slot).
REQ-010 pc_out  output  8  word address of the even slot; bit 0 always 0.
REQ-011 even_valid, odd_valid  output  1 each  slot holds a live instruction.
REQ-012 stall  input  1  decode cannot accept; hold outputs.
REQ-013 flush  input  1  redirect; discard all buffered state.
REQ-014 flush_pc  input  8  redirect target word address (odd allowed).

Function
REQ-015 States SHALL be FETCH and ISSUE only; reset enters FETCH.
REQ-016 FETCH: read_enable=1, even_valid=odd_valid=0; on line_valid=1 the whole line SHALL be captured into a 16-word line register and the state SHALL move to ISSUE next cycle.
REQ-017 line_valid in ISSUE, or in the same cycle as flush, SHALL be ignored.
REQ-018 ISSUE: instr_even/instr_odd SHALL be line words idx and idx+1, pc_out = fetch_pc + idx, idx a 4-bit even slot index.
REQ-019 A pair SHALL be consumed on any ISSUE cycle with stall=0; outputs SHALL be held unchanged while stall=1.
REQ-020 On consumption with idx<14: idx += 2, next pair visible the following cycle (one pair per cycle throughput).
REQ-021 On consumption with idx=14: state to FETCH, fetch_pc += 16 modulo 256 (240 wraps to 0), idx=0.
REQ-022 odd_valid SHALL be 1 throughout ISSUE; even_valid SHALL be 1 except on the first pair after a flush to an odd flush_pc.
REQ-023 flush SHALL take priority over stall, line_valid and consumption in every state: next cycle state=FETCH, fetch_pc = flush_pc with bits 3:0 cleared, idx = flush_pc[3:1]*2, a skip-even flag set to flush_pc[0].
REQ-024 The skip-even flag SHALL clear once the first pair after the flush is consumed or another flush occurs.
REQ-025 Latency: line_valid in cycle N -> first pair valid in cycle N+1; flush in cycle N -> read_enable with new fetch_pc in cycle N+1.

Reset
REQ-026 With reset=1 at a rising edge: state=FETCH, fetch_pc=0, idx=0, skip-even=0, line register cleared to 0.
REQ-027 During and after reset, before the first line is captured: read_enable=1, even_valid=odd_valid=0, instr_even=instr_odd=0, pc_out=0.
REQ-028 reset SHALL override flush and line_valid; reset mid-ISSUE SHALL discard the line.

Structure
REQ-029 Package spu_pkg SHALL hold INSTR_W=32, PC_W=8, LINE_WORDS=16, the instruction-word and line typedefs, and the FETCH/ISSUE state enum.
REQ-030 The block SHALL be a single module; no sub-module is required.

Verification
REQ-031 Reset 2 cycles, line_valid after 1 cycle with words 0..15 = 0x1000+i -> read_enable=1, fetch_pc=0; then 8 pairs pc_out=0,2,...,14, instr_even=0x1000+pc_out; then FETCH with fetch_pc=16.
REQ-032 stall=1 for 3 cycles at pc_out=6 -> outputs frozen at pc_out=6 for those cycles; pc_out=8 on the cycle after stall drops.
REQ-033 flush with flush_pc=37 -> next cycle read_enable=1, fetch_pc=32; after line -> pc_out=36, even_valid=0, odd_valid=1, instr_odd=word 5; next pair pc_out=38 with both valid.
REQ-034 Line at fetch_pc=240 fully consumed -> fetch_pc=0 (wrap), read_enable=1.
REQ-035 flush and line_valid in the same cycle in FETCH -> line ignored, fetch_pc = new target; flush with stall=1 in ISSUE -> flush wins.
REQ-036 reset asserted at pc_out=10 in ISSUE -> next cycle FETCH, fetch_pc=0, both valids 0.
